// File: rtl/fifo_ptr_status.sv
// Per-domain async FIFO pointer status: synchronizes the remote Gray pointer and
// derives registered full/empty, occupancy, almost flag and a sticky misuse error.
module fifo_ptr_status #(
  parameter int PTR_WIDTH = 8,
  parameter int MODE      = 0,
  parameter int ALMOST    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PTR_WIDTH-1:0] g_nxt,
  input  logic                 inc,
  input  logic [PTR_WIDTH-1:0] ptr_remote,
  input  logic                 err_clr,
  output logic                 flag,
  output logic                 almost,
  output logic [PTR_WIDTH-1:0] level,
  output logic                 err,
  output logic [PTR_WIDTH-1:0] rptr_sync
);

  localparam int DEPTH = 2 ** (PTR_WIDTH - 1);
  localparam logic [PTR_WIDTH-1:0] HI_TH     = PTR_WIDTH'(DEPTH - ALMOST);
  localparam logic [PTR_WIDTH-1:0] LO_TH     = PTR_WIDTH'(ALMOST);
  // Full pattern: remote pointer with its two MSBs inverted (one lap ahead in Gray).
  localparam logic [PTR_WIDTH-1:0] FULL_MASK = {2'b11, {(PTR_WIDTH-2){1'b0}}};
  localparam logic                 RD_SIDE   = (MODE != 0);

  function automatic logic [PTR_WIDTH-1:0] g2b(input logic [PTR_WIDTH-1:0] g);
    logic [PTR_WIDTH-1:0] b;
    b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) b[i] = g[i] ^ b[i+1];
    return b;
  endfunction

  logic [PTR_WIDTH-1:0] s1_q, s1_d;
  logic [PTR_WIDTH-1:0] s2_q, s2_d;
  logic [PTR_WIDTH-1:0] level_q, level_d;
  logic                 flag_q, flag_d;
  logic                 almost_q, almost_d;
  logic                 err_q, err_d;

  logic [PTR_WIDTH-1:0] b_loc, b_rem;

  // Plain two-flop synchronizer; nothing may sit between the stages.
  always_comb begin
    s1_d = ptr_remote;
    s2_d = s1_q;
  end

  always_comb begin
    b_loc    = g2b(g_nxt);
    b_rem    = g2b(s2_q);
    level_d  = '0;
    flag_d   = 1'b0;
    almost_d = 1'b0;
    if (RD_SIDE) begin
      level_d  = b_rem - b_loc;
      flag_d   = (g_nxt == s2_q);
      almost_d = (level_d <= LO_TH);
    end else begin
      level_d  = b_loc - b_rem;
      flag_d   = (g_nxt == (s2_q ^ FULL_MASK));
      almost_d = (level_d >= HI_TH);
    end
  end

  // A request against the currently registered flag wins over a clear.
  always_comb begin
    err_d = err_q;
    if (err_clr)      err_d = 1'b0;
    if (inc & flag_q) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      level_q  <= '0;
      flag_q   <= RD_SIDE;
      almost_q <= RD_SIDE;
      err_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      level_q  <= level_d;
      flag_q   <= flag_d;
      almost_q <= almost_d;
      err_q    <= err_d;
    end
  end

  assign flag      = flag_q;
  assign almost    = almost_q;
  assign level     = level_q;
  assign err       = err_q;
  assign rptr_sync = s2_q;

endmodule
